// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC and drives a variable-latency instruction memory.
// Returned words queue in order and are handed to decode as {pc+4, instr}.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 4
) (
    input  logic        clk_i,
    input  logic        rst_n,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        if_valid_o,
    output logic [31:0] if_pc4_o,
    output logic [31:0] if_instr_o,
    input  logic        if_ready_i,
    output logic [31:0] pc_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] instr;
    } fq_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } req_state_t;

    req_state_t    state;
    logic [31:0]   pc;
    logic [31:0]   issue_pc;
    logic          drop;
    fq_entry_t     fq [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;

    logic          outstanding;
    logic          rsp_fire;
    logic          issue_ok;
    logic          grant;
    logic          push;
    logic          pop;
    logic [CW:0]   occupancy;
    logic [31:0]   target;

    assign target      = redirect_pc_i & 32'hFFFF_FFFC;
    assign outstanding = (state == WAIT);
    assign occupancy   = {1'b0, count} + {{CW{1'b0}}, outstanding};

    // A response landing this cycle frees the slot, so the next
    // request may go out alongside it.
    assign issue_ok = rst_n
                    && !redirect_i
                    && (!outstanding || imem_rvalid_i)
                    && (occupancy < (CW+1)'(DEPTH));

    assign grant    = issue_ok && imem_gnt_i;
    assign rsp_fire = rst_n && outstanding && imem_rvalid_i;
    assign push     = rsp_fire && !drop && !redirect_i;
    assign pop      = if_valid_o && if_ready_i && !redirect_i;

    assign imem_req_o  = issue_ok;
    assign imem_addr_o = issue_ok ? pc : '0;
    assign pc_o        = pc;

    assign if_valid_o = rst_n && (count != '0);
    assign if_pc4_o   = if_valid_o ? fq[head].pc4 : '0;
    assign if_instr_o = if_valid_o ? fq[head].instr : '0;

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            issue_pc <= RESET_PC;
            drop     <= 1'b0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else if (redirect_i) begin
            pc    <= target;
            head  <= '0;
            tail  <= '0;
            count <= '0;
            // An in-flight fetch must still drain before the target goes out.
            if (outstanding && !imem_rvalid_i) begin
                state <= WAIT;
                drop  <= 1'b1;
            end else begin
                state <= IDLE;
                drop  <= 1'b0;
            end
        end else begin
            if (grant) begin
                pc       <= pc + 32'd4;
                issue_pc <= pc;
            end
            if (rsp_fire) begin
                drop <= 1'b0;
            end
            if (push) begin
                tail <= tail + PW'(1);
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (grant) begin
                state <= WAIT;
            end else if (issue_ok) begin
                state <= REQ;
            end else if (outstanding && !imem_rvalid_i) begin
                state <= WAIT;
            end else begin
                state <= IDLE;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fq[tail] <= '{pc4: issue_pc + 32'd4, instr: imem_rdata_i};
        end
    end

    assert property (@(posedge clk_i) disable iff (!rst_n)
        push |-> (count != CW'(DEPTH)));

    assert property (@(posedge clk_i) disable iff (!rst_n)
        occupancy <= (CW+1)'(DEPTH));

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed checks of fetch_stage against a
// small in-order memory responder with configurable latency.
module tb_fetch_stage;

    logic        clk_i = 1'b0;
    logic        rst_n;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        if_valid_o;
    logic [31:0] if_pc4_o;
    logic [31:0] if_instr_o;
    logic        if_ready_i;
    logic [31:0] pc_o;

    int vec  = 0;
    int errs = 0;
    int cyc  = 0;
    int mem_lat = 1;
    bit gnt_en  = 1'b1;

    typedef struct {
        int          due;
        logic [31:0] addr;
    } rsp_t;

    rsp_t        pend [$];
    logic [31:0] got [$];

    fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (4)
    ) dut (
        .clk_i         (clk_i),
        .rst_n         (rst_n),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .if_valid_o    (if_valid_o),
        .if_pc4_o      (if_pc4_o),
        .if_instr_o    (if_instr_o),
        .if_ready_i    (if_ready_i),
        .pc_o          (pc_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return 32'h1300_0000 | a;
    endfunction

    // Memory: drives at negedge, samples the grant just before posedge.
    initial begin
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
        forever begin
            @(negedge clk_i);
            cyc++;
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = '0;
            if (pend.size() != 0 && pend[0].due <= cyc) begin
                imem_rvalid_i = 1'b1;
                imem_rdata_i  = word_at(pend[0].addr);
                void'(pend.pop_front());
            end
            imem_gnt_i = gnt_en;
            #4;
            if (imem_req_o && imem_gnt_i) begin
                pend.push_back('{due: cyc + mem_lat, addr: imem_addr_o});
            end
            if (if_valid_o && if_ready_i) begin
                got.push_back(if_pc4_o);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(negedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        step();
        rst_n      = 1'b0;
        redirect_i = 1'b0;
        pend.delete();
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        if_ready_i    = 1'b1;
        step();
        step();
        #1;
        vec++; if (imem_req_o !== 1'b0) begin errs++;
            $display("FAIL rst_req got=%b exp=0", imem_req_o); end
        vec++; if (imem_addr_o !== 32'h0) begin errs++;
            $display("FAIL rst_addr got=%h exp=0", imem_addr_o); end
        vec++; if (if_valid_o !== 1'b0) begin errs++;
            $display("FAIL rst_valid got=%b exp=0", if_valid_o); end
        vec++; if (if_pc4_o !== 32'h0) begin errs++;
            $display("FAIL rst_pc4 got=%h exp=0", if_pc4_o); end
        vec++; if (if_instr_o !== 32'h0) begin errs++;
            $display("FAIL rst_instr got=%h exp=0", if_instr_o); end
        vec++; if (pc_o !== 32'h0) begin errs++;
            $display("FAIL rst_pc got=%h exp=0", pc_o); end
    endtask

    task automatic test_stream();
        if_ready_i = 1'b1;
        gnt_en     = 1'b1;
        mem_lat    = 1;
        do_reset();
        #1;
        vec++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin errs++;
            $display("FAIL st_req0 got=%b/%h exp=1/0", imem_req_o, imem_addr_o); end
        vec++; if (if_valid_o !== 1'b0) begin errs++;
            $display("FAIL st_valid0 got=%b exp=0", if_valid_o); end
        step(); #1;
        vec++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h4) begin errs++;
            $display("FAIL st_req1 got=%b/%h exp=1/4", imem_req_o, imem_addr_o); end
        vec++; if (if_valid_o !== 1'b0) begin errs++;
            $display("FAIL st_valid1 got=%b exp=0", if_valid_o); end
        step(); #1;
        vec++; if (if_valid_o !== 1'b1 || if_pc4_o !== 32'h4) begin errs++;
            $display("FAIL st_head0 got=%b/%h exp=1/4", if_valid_o, if_pc4_o); end
        vec++; if (if_instr_o !== word_at(32'h0)) begin errs++;
            $display("FAIL st_instr0 got=%h exp=%h", if_instr_o, word_at(32'h0)); end
        vec++; if (imem_addr_o !== 32'h8) begin errs++;
            $display("FAIL st_addr2 got=%h exp=8", imem_addr_o); end
        step(); #1;
        vec++; if (if_valid_o !== 1'b1 || if_pc4_o !== 32'h8) begin errs++;
            $display("FAIL st_head1 got=%b/%h exp=1/8", if_valid_o, if_pc4_o); end
        step(); #1;
        vec++; if (if_pc4_o !== 32'hC || if_instr_o !== word_at(32'h8)) begin errs++;
            $display("FAIL st_head2 got=%h/%h exp=c/%h", if_pc4_o, if_instr_o,
                     word_at(32'h8)); end
    endtask

    task automatic test_backpressure();
        logic [31:0] g;
        if_ready_i = 1'b0;
        gnt_en     = 1'b1;
        mem_lat    = 1;
        do_reset();
        repeat (10) step();
        #1;
        vec++; if (imem_req_o !== 1'b0) begin errs++;
            $display("FAIL bp_req got=%b exp=0", imem_req_o); end
        vec++; if (if_valid_o !== 1'b1 || if_pc4_o !== 32'h4) begin errs++;
            $display("FAIL bp_head got=%b/%h exp=1/4", if_valid_o, if_pc4_o); end
        vec++; if (pc_o !== 32'h10) begin errs++;
            $display("FAIL bp_pc got=%h exp=10", pc_o); end
        got.delete();
        if_ready_i = 1'b1;
        repeat (8) step();
        #1;
        vec++; if (got.size() != 8) begin errs++;
            $display("FAIL bp_count got=%0d exp=8", got.size()); end
        for (int i = 0; i < 8; i++) begin
            g = (i < got.size()) ? got[i] : 32'hDEAD_DEAD;
            vec++; if (g !== 32'(4 * (i + 1))) begin errs++;
                $display("FAIL bp_pc4[%0d] got=%h exp=%h", i, g, 32'(4 * (i + 1))); end
        end
    endtask

    task automatic test_gnt_stall();
        if_ready_i = 1'b1;
        gnt_en     = 1'b0;
        mem_lat    = 1;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            #1;
            vec++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin errs++;
                $display("FAIL gs_hold[%0d] got=%b/%h exp=1/0", i, imem_req_o,
                         imem_addr_o); end
            vec++; if (pc_o !== 32'h0) begin errs++;
                $display("FAIL gs_pc[%0d] got=%h exp=0", i, pc_o); end
            if (i == 4) gnt_en = 1'b1;
            step();
        end
        #1;
        vec++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin errs++;
            $display("FAIL gs_gnt got=%b/%h exp=1/0", imem_req_o, imem_addr_o); end
        step(); #1;
        vec++; if (pc_o !== 32'h4 || imem_addr_o !== 32'h4) begin errs++;
            $display("FAIL gs_adv got=%h/%h exp=4/4", pc_o, imem_addr_o); end
        step(); #1;
        vec++; if (if_valid_o !== 1'b1 || if_pc4_o !== 32'h4) begin errs++;
            $display("FAIL gs_head got=%b/%h exp=1/4", if_valid_o, if_pc4_o); end
    endtask

    task automatic test_redirect_outstanding();
        if_ready_i = 1'b1;
        gnt_en     = 1'b1;
        mem_lat    = 3;
        do_reset();
        step();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h40;
        #1;
        vec++; if (imem_req_o !== 1'b0) begin errs++;
            $display("FAIL ro_req_redir got=%b exp=0", imem_req_o); end
        step();
        redirect_i = 1'b0;
        #1;
        vec++; if (pc_o !== 32'h40 || imem_req_o !== 1'b0) begin errs++;
            $display("FAIL ro_drop_wait got=%h/%b exp=40/0", pc_o, imem_req_o); end
        step(); #1;
        vec++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h40) begin errs++;
            $display("FAIL ro_retarget got=%b/%h exp=1/40", imem_req_o,
                     imem_addr_o); end
        for (int i = 0; i < 4; i++) begin
            if (i != 0) step();
            #1;
            vec++; if (if_valid_o !== 1'b0) begin errs++;
                $display("FAIL ro_stale[%0d] got=%b exp=0", i, if_valid_o); end
        end
        step(); #1;
        vec++; if (if_valid_o !== 1'b1 || if_pc4_o !== 32'h44) begin errs++;
            $display("FAIL ro_head got=%b/%h exp=1/44", if_valid_o, if_pc4_o); end
        vec++; if (if_instr_o !== word_at(32'h40)) begin errs++;
            $display("FAIL ro_instr got=%h exp=%h", if_instr_o, word_at(32'h40)); end
    endtask

    task automatic test_redirect_collision();
        if_ready_i = 1'b1;
        gnt_en     = 1'b1;
        mem_lat    = 1;
        do_reset();
        step();
        step();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h83;
        #1;
        vec++; if (if_valid_o !== 1'b1 || imem_req_o !== 1'b0) begin errs++;
            $display("FAIL rc_same got=%b/%b exp=1/0", if_valid_o, imem_req_o); end
        step();
        redirect_i = 1'b0;
        #1;
        vec++; if (if_valid_o !== 1'b0) begin errs++;
            $display("FAIL rc_flush got=%b exp=0", if_valid_o); end
        vec++; if (pc_o !== 32'h80) begin errs++;
            $display("FAIL rc_align got=%h exp=80", pc_o); end
        vec++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h80) begin errs++;
            $display("FAIL rc_req got=%b/%h exp=1/80", imem_req_o, imem_addr_o); end
        step(); #1;
        vec++; if (if_valid_o !== 1'b0) begin errs++;
            $display("FAIL rc_gap got=%b exp=0", if_valid_o); end
        step(); #1;
        vec++; if (if_valid_o !== 1'b1 || if_pc4_o !== 32'h84) begin errs++;
            $display("FAIL rc_head got=%b/%h exp=1/84", if_valid_o, if_pc4_o); end
        vec++; if (if_instr_o !== word_at(32'h80)) begin errs++;
            $display("FAIL rc_instr got=%h exp=%h", if_instr_o, word_at(32'h80)); end
    endtask

    task automatic test_reset_midflight();
        if_ready_i = 1'b0;
        gnt_en     = 1'b1;
        mem_lat    = 3;
        do_reset();
        repeat (10) step();
        #1;
        vec++; if (if_valid_o !== 1'b1 || if_pc4_o !== 32'h4) begin errs++;
            $display("FAIL rm_pre got=%b/%h exp=1/4", if_valid_o, if_pc4_o); end
        vec++; if (pc_o !== 32'h10 || imem_req_o !== 1'b0) begin errs++;
            $display("FAIL rm_occ got=%h/%b exp=10/0", pc_o, imem_req_o); end
        step();
        rst_n  = 1'b0;
        gnt_en = 1'b0;
        #1;
        vec++; if (if_valid_o !== 1'b0 || if_pc4_o !== 32'h0) begin errs++;
            $display("FAIL rm_out got=%b/%h exp=0/0", if_valid_o, if_pc4_o); end
        vec++; if (if_instr_o !== 32'h0 || imem_req_o !== 1'b0) begin errs++;
            $display("FAIL rm_out2 got=%h/%b exp=0/0", if_instr_o, imem_req_o); end
        step();
        rst_n = 1'b1;
        #1;
        vec++; if (pc_o !== 32'h0 || if_valid_o !== 1'b0) begin errs++;
            $display("FAIL rm_restart got=%h/%b exp=0/0", pc_o, if_valid_o); end
        vec++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin errs++;
            $display("FAIL rm_req got=%b/%h exp=1/0", imem_req_o, imem_addr_o); end
        step(); #1;
        vec++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin errs++;
            $display("FAIL rm_late_req got=%b/%h exp=1/0", imem_req_o,
                     imem_addr_o); end
        gnt_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(); #1;
            vec++; if (if_valid_o !== 1'b0) begin errs++;
                $display("FAIL rm_ignore[%0d] got=%b exp=0", i, if_valid_o); end
        end
        step(); #1;
        vec++; if (if_valid_o !== 1'b1 || if_pc4_o !== 32'h4) begin errs++;
            $display("FAIL rm_head got=%b/%h exp=1/4", if_valid_o, if_pc4_o); end
        vec++; if (if_instr_o !== word_at(32'h0)) begin errs++;
            $display("FAIL rm_instr got=%h exp=%h", if_instr_o, word_at(32'h0)); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_gnt_stall();
        test_redirect_outstanding();
        test_redirect_collision();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch front end of the 5-stage pipeline; sits directly upstream of the IF/ID register and decode.
- Owns the PC, issues requests to a variable-latency instruction memory and buffers returned words in a small in-order queue.
- Presents {PC+4, instr} to decode under a valid/ready handshake, so decode can stall.
- Flushes on a taken-branch redirect from the MEM stage.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset
DEPTH, 4, fetch queue entries (power of two, >=2)

Ports:
clk_i  in  1  clock, rising edge
rst_n  in  1  reset; synchronous, active-low
redirect_i  in  1  taken branch from MEM stage (PCsrc)
redirect_pc_i  in  32  branch target
imem_req_o  out  1  fetch request valid
imem_addr_o  out  32  fetch address (word aligned)
imem_gnt_i  in  1  request accepted this cycle
imem_rvalid_i  in  1  response valid, in order, >=1 cycle after grant
imem_rdata_i  in  32  instruction word
if_valid_o  out  1  queue head valid
if_pc4_o  out  32  head PC+4 (0 when invalid)
if_instr_o  out  32  head instruction (0 = nop bubble when invalid)
if_ready_i  in  1  decode accepts head
pc_o  out  32  next address to fetch (debug)

Behaviour:
- Clock and reset: one clock, clk_i. Reset is rst_n, synchronous, active-low.
- Reset cycle: pc=RESET_PC, queue empty, outstanding=0, drop=0. All outputs 0 except pc_o=RESET_PC.
- Request FSM states:
  - IDLE: no request pending.
  - REQ: imem_req_o=1; leaves on grant.
  - WAIT: one request outstanding; leaves on rvalid.
- Issue rule: imem_req_o=1 only when count + outstanding < DEPTH and no redirect this cycle.
  - imem_addr_o = pc. pc advances by 4 on grant.
  - At most one request outstanding.
  - A new request may be issued in the same cycle the previous response arrives, giving 1 instr/cycle with 1-cycle memory.
- Request stability: while imem_req_o=1 and imem_gnt_i=0, address and request are held stable. The only exception is a redirect, which withdraws or retargets the request.
- Response: on imem_rvalid_i with drop=0, push {issue_pc+4, imem_rdata_i}. The issue PC is latched at grant. The issue rule guarantees space, so pushing into a full queue is illegal and cannot occur.
- Output:
  - if_valid_o = (count != 0); head fields are driven only when valid, zeros otherwise.
  - Pop when if_valid_o & if_ready_i.
  - Push and pop in the same cycle leave count unchanged.
- Queue: circular, head and tail pointers wrap modulo DEPTH; count ranges 0..DEPTH.
- Redirect (redirect_i=1) has highest priority:
  - Queue cleared next cycle; any same-cycle push or pop is ignored.
  - pc <= redirect_pc_i.
  - If a request is outstanding (granted, no response yet), drop <= 1. The next response is discarded and drop clears.
  - A response arriving in the redirect cycle itself is discarded, with no drop set.
  - An ungranted request is withdrawn. The redirect target is requested starting next cycle, subject to the drop wait.
  - Stale data must never reach if_valid_o.
- Latency (gnt same cycle, rvalid next cycle, queue empty): request at cycle t, push at end of t+1, if_valid_o at t+2.
- Reset mid-operation: everything returns to reset state the following cycle. An in-flight response after reset is ignored (drop=0, outstanding=0 so rvalid is discarded).
- Misaligned redirect_pc_i: low 2 bits are forced to 0.

Test Plan:
1. Reset release with RESET_PC=0, 1-cycle memory, ready=1 -> addrs 0,4,8,... one per cycle; first if_valid_o 2 cycles after first request, if_pc4_o=4,8,12 in order.
2. Backpressure: ready=0 for 10 cycles -> exactly 4 entries buffered, imem_req_o drops to 0. Ready=1 -> pc4 4,8,12,16,20... in order, no duplicates or gaps.
3. gnt=0 for 5 cycles -> imem_req_o=1 and imem_addr_o constant throughout; pc_o unchanged until the grant.
4. 3-cycle memory, redirect to 0x40 while a request is outstanding -> old response discarded; next valid has pc4=0x44 and instr from 0x40.
5. Redirect, pop and rvalid all in the same cycle -> next cycle if_valid_o=0, count=0, then fetch resumes at the target.
6. rst_n=0 for 1 cycle with a full queue and an outstanding request -> outputs zero, then fetch restarts at RESET_PC, and a late rvalid is ignored.
